// File: rtl/turbo_pkg.sv
// Shared types and defaults for the turbo encoder output ping-pong buffer.
package turbo_pkg;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_TAIL} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA, R_TAIL} rd_state_t;

  localparam int TAIL_LEN_DEFAULT = 4;
  localparam int K_LONG_DEFAULT   = 6144;
  localparam int K_SHORT_DEFAULT  = 1056;

  // Instances with non-default lengths pass their own pair.
  function automatic int block_len(input logic length_flag,
                                   input int k_long  = K_LONG_DEFAULT,
                                   input int k_short = K_SHORT_DEFAULT);
    return length_flag ? k_long : k_short;
  endfunction

endpackage

// File: rtl/turbo_bank_ram.sv
// Simple dual-port block RAM: one write port, one registered read port.
module turbo_bank_ram #(
  parameter int W     = 3,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/turbo_out_pingpong.sv
// N-bank block buffer: captures data+tail per code block, replays it through
// a ready/valid port via a registered RAM read and a 2-entry skid.
module turbo_out_pingpong
  import turbo_pkg::*;
#(
  parameter int W         = 3,
  parameter int K_LONG    = K_LONG_DEFAULT,
  parameter int K_SHORT   = K_SHORT_DEFAULT,
  parameter int TAIL_LEN  = TAIL_LEN_DEFAULT,
  parameter int NUM_BANKS = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enc_valid,
  input  logic [W-1:0]                   enc_data,
  input  logic                           length,
  input  logic                           trl_valid,
  input  logic [W-1:0]                   trl_data,
  output logic                           in_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [W-1:0]                   out_data,
  output logic                           out_sop,
  output logic                           out_eop,
  output logic                           out_tail,
  output logic                           length_out,
  output logic [$clog2(NUM_BANKS+1)-1:0] banks_full,
  output logic                           proto_err
);

  localparam int BANK_DEPTH = K_LONG + TAIL_LEN;
  localparam int DEPTH      = NUM_BANKS * BANK_DEPTH;
  localparam int AW         = $clog2(DEPTH);
  localparam int CW         = $clog2(BANK_DEPTH);
  localparam int PW         = $clog2(NUM_BANKS);
  localparam int BW         = $clog2(NUM_BANKS+1);

  typedef struct packed {
    logic sop;
    logic eop;
    logic tail;
    logic len;
  } tag_t;

  typedef struct packed {
    logic [W-1:0] data;
    tag_t         tag;
  } sym_t;

  wr_state_t          wstate, wstate_nx;
  rd_state_t          rstate, rstate_nx;
  logic [PW-1:0]      wptr, rptr;
  logic [CW-1:0]      wcnt, wcnt_nx, rcnt, rcnt_nx;
  logic [NUM_BANKS-1:0] len_bank;
  logic               wr_en, len_latch, commit, err;
  logic [AW-1:0]      wr_addr, rd_addr;
  logic [W-1:0]       wr_data, rd_data;
  int                 wk, rk, wr_off, rd_off;
  logic               issue, rel, credit, pop, rd_valid;
  tag_t               tag_nx, rd_tag;
  sym_t               ent0, ent1, incoming;
  logic [1:0]         skid_cnt;

  assign in_ready  = (wstate != W_IDLE) || (int'(banks_full) < NUM_BANKS);
  assign out_valid = (skid_cnt != 2'd0);
  assign pop       = out_valid && out_ready;

  always_comb begin
    wstate_nx = wstate;
    wcnt_nx   = wcnt;
    wr_en     = 1'b0;
    wr_off    = 0;
    len_latch = 1'b0;
    commit    = 1'b0;
    err       = 1'b0;
    wk        = block_len((wstate == W_IDLE) ? length : len_bank[wptr], K_LONG, K_SHORT);
    case (wstate)
      W_IDLE: begin
        if (enc_valid && in_ready) begin
          wr_en     = 1'b1;
          len_latch = 1'b1;
          if (wk == 1) begin
            wstate_nx = W_TAIL;
            wcnt_nx   = '0;
          end else begin
            wstate_nx = W_DATA;
            wcnt_nx   = CW'(1);
          end
        end else if (enc_valid) begin
          err = 1'b1;
        end
        if (trl_valid) err = 1'b1;
      end
      W_DATA: begin
        if (enc_valid) begin
          wr_en  = 1'b1;
          wr_off = int'(wcnt);
          if (int'(wcnt) == wk - 1) begin
            wstate_nx = W_TAIL;
            wcnt_nx   = '0;
          end else begin
            wcnt_nx = wcnt + CW'(1);
          end
        end
        if (trl_valid) err = 1'b1;
      end
      W_TAIL: begin
        if (enc_valid) err = 1'b1;
        if (trl_valid) begin
          wr_en  = 1'b1;
          wr_off = K_LONG + int'(wcnt);
          if (int'(wcnt) == TAIL_LEN - 1) begin
            wstate_nx = W_IDLE;
            wcnt_nx   = '0;
            commit    = 1'b1;
          end else begin
            wcnt_nx = wcnt + CW'(1);
          end
        end
      end
      default: wstate_nx = W_IDLE;
    endcase
  end

  assign wr_addr = AW'(int'(wptr) * BANK_DEPTH + wr_off);
  assign wr_data = (wstate == W_TAIL) ? trl_data : enc_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate    <= W_IDLE;
      wcnt      <= '0;
      wptr      <= '0;
      len_bank  <= '0;
      proto_err <= 1'b0;
    end else begin
      wstate <= wstate_nx;
      wcnt   <= wcnt_nx;
      if (len_latch) len_bank[wptr] <= length;
      if (commit) wptr <= wptr + PW'(1);
      if (err) proto_err <= 1'b1;
    end
  end

  // Reads run ahead of acceptance, limited by skid room, so the next bank
  // can be fetched before the current block has drained.
  always_comb begin
    rstate_nx = rstate;
    rcnt_nx   = rcnt;
    issue     = 1'b0;
    rel       = 1'b0;
    rd_off    = 0;
    rk        = block_len(len_bank[rptr], K_LONG, K_SHORT);
    credit    = (int'(skid_cnt) + int'(rd_valid) - int'(pop)) <= 1;
    tag_nx    = '{sop: (rstate == R_FETCH), eop: 1'b0, tail: (rstate == R_TAIL),
                  len: len_bank[rptr]};
    case (rstate)
      R_IDLE: if (banks_full != '0) rstate_nx = R_FETCH;
      R_FETCH: begin
        if (credit) begin
          issue = 1'b1;
          if (rk == 1) begin
            rstate_nx = R_TAIL;
            rcnt_nx   = '0;
          end else begin
            rstate_nx = R_DATA;
            rcnt_nx   = CW'(1);
          end
        end
      end
      R_DATA: begin
        if (credit) begin
          issue  = 1'b1;
          rd_off = int'(rcnt);
          if (int'(rcnt) == rk - 1) begin
            rstate_nx = R_TAIL;
            rcnt_nx   = '0;
          end else begin
            rcnt_nx = rcnt + CW'(1);
          end
        end
      end
      R_TAIL: begin
        if (credit) begin
          issue  = 1'b1;
          rd_off = K_LONG + int'(rcnt);
          if (int'(rcnt) == TAIL_LEN - 1) begin
            tag_nx.eop = 1'b1;
            rel        = 1'b1;
            rcnt_nx    = '0;
            rstate_nx  = (int'(banks_full) > 1 || commit) ? R_FETCH : R_IDLE;
          end else begin
            rcnt_nx = rcnt + CW'(1);
          end
        end
      end
      default: rstate_nx = R_IDLE;
    endcase
  end

  assign rd_addr = AW'(int'(rptr) * BANK_DEPTH + rd_off);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate     <= R_IDLE;
      rcnt       <= '0;
      rptr       <= '0;
      banks_full <= '0;
      rd_valid   <= 1'b0;
      rd_tag     <= '0;
    end else begin
      rstate   <= rstate_nx;
      rcnt     <= rcnt_nx;
      rd_valid <= issue;
      if (issue) rd_tag <= tag_nx;
      if (rel) rptr <= rptr + PW'(1);
      if (commit && !rel) banks_full <= banks_full + BW'(1);
      else if (rel && !commit) banks_full <= banks_full - BW'(1);
    end
  end

  turbo_bank_ram #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (issue),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign incoming = {rd_data, rd_tag};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_cnt <= 2'd0;
      ent0     <= '0;
      ent1     <= '0;
    end else begin
      case ({rd_valid, pop})
        2'b10: begin
          if (skid_cnt == 2'd0) ent0 <= incoming;
          else ent1 <= incoming;
          skid_cnt <= skid_cnt + 2'd1;
        end
        2'b01: begin
          ent0     <= ent1;
          skid_cnt <= skid_cnt - 2'd1;
        end
        2'b11: begin
          if (skid_cnt == 2'd1) begin
            ent0 <= incoming;
          end else begin
            ent0 <= ent1;
            ent1 <= incoming;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data   = ent0.data;
  assign out_sop    = out_valid && ent0.tag.sop;
  assign out_eop    = out_valid && ent0.tag.eop;
  assign out_tail   = out_valid && ent0.tag.tail;
  assign length_out = ent0.tag.len;

endmodule

// File: tb/tb_turbo_out_pingpong.sv
// Scoreboard bench for turbo_out_pingpong with small block lengths.
`timescale 1ns/1ps
module tb_turbo_out_pingpong;

  localparam int W         = 3;
  localparam int K_LONG    = 6;
  localparam int K_SHORT   = 4;
  localparam int TAIL_LEN  = 4;
  localparam int NUM_BANKS = 2;
  localparam int BFW       = $clog2(NUM_BANKS+1);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           enc_valid = 1'b0;
  logic [W-1:0]   enc_data = '0;
  logic           length = 1'b0;
  logic           trl_valid = 1'b0;
  logic [W-1:0]   trl_data = '0;
  logic           in_ready, out_valid, out_sop, out_eop, out_tail, length_out, proto_err;
  logic [W-1:0]   out_data;
  logic [BFW-1:0] banks_full;
  wire            out_ready;
  logic           ready_set = 1'b1;
  logic           rand_mode = 1'b0;
  logic           rnd_bit = 1'b1;

  typedef struct packed {
    logic [W-1:0] data;
    logic         sop;
    logic         eop;
    logic         tail;
    logic         len;
  } sym_t;

  typedef struct {
    logic len;
    int   exp_syms;
  } vec_t;

  sym_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   acc_count = 0;
  int   cyc = 0;
  int   last_eop_cyc = -100;
  int   last_gap = 0;

  assign out_ready = rand_mode ? rnd_bit : ready_set;

  turbo_out_pingpong #(
    .W(W), .K_LONG(K_LONG), .K_SHORT(K_SHORT), .TAIL_LEN(TAIL_LEN), .NUM_BANKS(NUM_BANKS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enc_valid  (enc_valid),
    .enc_data   (enc_data),
    .length     (length),
    .trl_valid  (trl_valid),
    .trl_data   (trl_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .out_tail   (out_tail),
    .length_out (length_out),
    .banks_full (banks_full),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Output monitor: every accepted symbol is popped from the scoreboard.
  always @(negedge clk) begin
    sym_t act, exp;
    cyc++;
    if (out_valid && out_ready) begin
      act = {out_data, out_sop, out_eop, out_tail, length_out};
      acc_count++;
      if (out_sop) last_gap = cyc - last_eop_cyc;
      if (out_eop) last_eop_cyc = cyc;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_sym actual=%0h required=none", act);
      end else begin
        exp = sb.pop_front();
        checkOutput("sym", int'(act), int'(exp));
      end
    end
  end

  // Writes one block; kept=0 means the DUT must discard it.
  task automatic applyStimulus(input logic len, input bit kept, input bit glitch, input bit wait_ready);
    int   k;
    int   n;
    sym_t s;
    logic [W-1:0] d;
    k = len ? K_LONG : K_SHORT;
    if (wait_ready) begin
      n = 0;
      while (!in_ready && n < 1000) begin
        @(posedge clk); #1;
        n++;
      end
      if (!in_ready) begin
        checks++;
        failures++;
        $display("[TB] FAIL in_ready_timeout actual=0 required=1");
      end
    end
    for (int i = 0; i < k; i++) begin
      d = W'($urandom_range(0, 7));
      enc_valid = 1'b1;
      enc_data  = d;
      length    = (i == 0) ? len : ~len;
      s.data = d; s.sop = (i == 0); s.eop = 1'b0; s.tail = 1'b0; s.len = len;
      if (kept) sb.push_back(s);
      @(posedge clk); #1;
      if (glitch && i == 1) begin
        enc_valid = 1'b0;
        trl_valid = 1'b1;
        trl_data  = 3'd7;
        @(posedge clk); #1;
        trl_valid = 1'b0;
      end
    end
    enc_valid = 1'b0;
    for (int i = 0; i < TAIL_LEN; i++) begin
      d = W'($urandom_range(0, 7));
      trl_valid = 1'b1;
      trl_data  = d;
      s.data = d; s.sop = 1'b0; s.eop = (i == TAIL_LEN-1); s.tail = 1'b1; s.len = len;
      if (kept) sb.push_back(s);
      @(posedge clk); #1;
    end
    trl_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (8) @(posedge clk);
    #1;
    checkOutput(name, sb.size(), 0);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_out_valid"}, out_valid, 0);
    checkOutput({tag, "_out_sop"}, out_sop, 0);
    checkOutput({tag, "_out_eop"}, out_eop, 0);
    checkOutput({tag, "_out_tail"}, out_tail, 0);
    checkOutput({tag, "_length_out"}, length_out, 0);
    checkOutput({tag, "_out_data"}, out_data, 0);
    checkOutput({tag, "_banks_full"}, banks_full, 0);
    checkOutput({tag, "_proto_err"}, proto_err, 0);
    checkOutput({tag, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl[4];
    int   lat, acc0, total, n;
    tbl[0] = '{len: 1'b0, exp_syms: 8};
    tbl[1] = '{len: 1'b1, exp_syms: 10};
    tbl[2] = '{len: 1'b1, exp_syms: 10};
    tbl[3] = '{len: 1'b0, exp_syms: 8};

    repeat (3) @(posedge clk);
    #1;
    checkIdle("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] single short block");
    acc0 = acc_count;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("t1_latency", lat, 3);
    drain("t1_drain");
    checkOutput("t1_count", acc_count - acc0, tbl[0].exp_syms);

    $display("[TB] long then short back to back");
    acc0 = acc_count;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    drain("t2_drain");
    checkOutput("t2_count", acc_count - acc0, 18);
    checkOutput("t2_gap", last_gap, 1);

    $display("[TB] trl_valid during data");
    checkOutput("t5_err_before", proto_err, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("t5_err_after", proto_err, 1);
    drain("t5_drain");

    $display("[TB] overflow with out_ready low");
    rst = 1'b1; sb.delete(); #3; rst = 1'b0;
    @(posedge clk); #1;
    ready_set = 1'b0;
    checkOutput("t3_err_clear", proto_err, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("t3_full1", banks_full, 1);
    checkOutput("t3_ready1", in_ready, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("t3_full2", banks_full, 2);
    checkOutput("t3_ready2", in_ready, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t3_err", proto_err, 1);
    checkOutput("t3_full3", banks_full, 2);
    ready_set = 1'b1;
    drain("t3_drain");
    checkOutput("t3_empty", banks_full, 0);
    checkOutput("t3_ready_end", in_ready, 1);

    $display("[TB] random back-pressure over 20 blocks");
    rand_mode = 1'b1;
    acc0 = acc_count;
    total = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(tbl[i % 4].len, 1'b1, 1'b0, 1'b1);
      total += tbl[i % 4].exp_syms;
    end
    drain("t4_drain");
    rand_mode = 1'b0;
    checkOutput("t4_count", acc_count - acc0, total);

    $display("[TB] reset mid-output");
    rst = 1'b1; sb.delete(); #3; rst = 1'b0;
    @(posedge clk); #1;
    acc0 = acc_count;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    n = 0;
    while (acc_count < acc0 + 3 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("t6_started", (acc_count >= acc0 + 3) ? 1 : 0, 1);
    checkOutput("t6_len_before", length_out, 1);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    checkIdle("t6_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    acc0 = acc_count;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    drain("t6_drain");
    checkOutput("t6_count", acc_count - acc0, tbl[3].exp_syms);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
